// File: rtl/alu_pkg.sv
// Shared opcode, control-width and FSM state definitions for the sequential ALU.
package alu_pkg;

    localparam int CTRL_W = 3;

    localparam logic [CTRL_W-1:0] OP_ADD = 3'd0;
    localparam logic [CTRL_W-1:0] OP_SUB = 3'd1;
    localparam logic [CTRL_W-1:0] OP_MUL = 3'd2;
    localparam logic [CTRL_W-1:0] OP_DIV = 3'd3;
    localparam logic [CTRL_W-1:0] OP_MOD = 3'd4;
    localparam logic [CTRL_W-1:0] OP_AND = 3'd5;
    localparam logic [CTRL_W-1:0] OP_OR  = 3'd6;
    localparam logic [CTRL_W-1:0] OP_XOR = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_divider.sv
// Iterative restoring divider: one quotient bit per cycle, MSB first, WIDTH cycles.
// done, quotient and remainder are valid together on the final iteration cycle.
module alu_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             busy;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    // A set top bit of trial means the subtraction borrowed: keep the shifted remainder.
    always_comb begin
        shifted  = {rem_q, quo_q[WIDTH-1]};
        trial    = shifted - {1'b0, dvs_q};
        rem_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_next = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
    end

    assign done      = busy && (cnt == CNT_W'(1));
    assign quotient  = quo_next;
    assign remainder = rem_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= CNT_W'(WIDTH);
        end else if (busy) begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                busy <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
        end else if (busy) begin
            rem_q <= rem_next;
            quo_q <= quo_next;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked unsigned ALU: single-cycle add/sub/mul/logic, iterative div/mod,
// one operation in flight, result held until the consumer accepts it.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [WIDTH-1:0]  data0_i,
    input  logic [WIDTH-1:0]  data1_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [WIDTH-1:0]  result_o,
    output logic [WIDTH-1:0]  result_hi_o,
    output logic              carry_o,
    output logic              zero_o,
    output logic              err_o
);

    state_t             state;
    state_t             state_next;
    logic               accept;
    logic               is_div_op;
    logic               div_start;
    logic               div_done;
    logic               mod_q;
    logic [WIDTH-1:0]   div_quo;
    logic [WIDTH-1:0]   div_rem;
    logic [WIDTH-1:0]   div_res;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   calc_lo;
    logic [WIDTH-1:0]   calc_hi;
    logic               calc_carry;
    logic               calc_err;

    assign is_div_op = (ctrl_i == OP_DIV) || (ctrl_i == OP_MOD);
    assign accept    = (state == ST_IDLE) && valid_i;
    assign div_res   = mod_q ? div_rem : div_quo;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (valid_i) begin
                    state_next = (is_div_op && (data1_i != '0)) ? ST_BUSY : ST_DONE;
                end
            end
            ST_BUSY: begin
                if (div_done) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (ready_i) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        ready_o   = (state == ST_IDLE);
        valid_o   = (state == ST_DONE);
        div_start = accept && is_div_op && (data1_i != '0);
    end

    // Single-cycle results; the div/mod entries only matter for a zero divisor.
    always_comb begin
        sum        = {1'b0, data0_i} + {1'b0, data1_i};
        prod       = {{WIDTH{1'b0}}, data0_i} * {{WIDTH{1'b0}}, data1_i};
        calc_lo    = '0;
        calc_hi    = '0;
        calc_carry = 1'b0;
        calc_err   = 1'b0;
        case (ctrl_i)
            OP_ADD: begin
                calc_lo    = sum[WIDTH-1:0];
                calc_carry = sum[WIDTH];
            end
            OP_SUB: begin
                calc_lo    = data0_i - data1_i;
                calc_carry = (data0_i < data1_i);
            end
            OP_MUL: begin
                calc_lo = prod[WIDTH-1:0];
                calc_hi = prod[2*WIDTH-1:WIDTH];
            end
            OP_DIV: begin
                calc_lo  = '1;
                calc_err = 1'b1;
            end
            OP_MOD: begin
                calc_lo  = data0_i;
                calc_err = 1'b1;
            end
            OP_AND:  calc_lo = data0_i & data1_i;
            OP_OR:   calc_lo = data0_i | data1_i;
            OP_XOR:  calc_lo = data0_i ^ data1_i;
            default: calc_lo = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            result_o    <= '0;
            result_hi_o <= '0;
            carry_o     <= 1'b0;
            zero_o      <= 1'b0;
            err_o       <= 1'b0;
        end else if (accept && !div_start) begin
            result_o    <= calc_lo;
            result_hi_o <= calc_hi;
            carry_o     <= calc_carry;
            zero_o      <= (calc_lo == '0);
            err_o       <= calc_err;
        end else if ((state == ST_BUSY) && div_done) begin
            result_o    <= div_res;
            result_hi_o <= '0;
            carry_o     <= 1'b0;
            zero_o      <= (div_res == '0);
            err_o       <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            mod_q <= (ctrl_i == OP_MOD);
        end
    end

    alu_divider #(
        .WIDTH(WIDTH)
    ) u_divider (
        .clk      (clk_i),
        .rst      (rst_i),
        .start    (div_start),
        .dividend (data0_i),
        .divisor  (data1_i),
        .done     (div_done),
        .quotient (div_quo),
        .remainder(div_rem)
    );

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed cases with literal expectations plus randomized
// traffic compared every cycle against a latency/arithmetic reference model.
module tb_alu_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic         valid_i = 1'b0;
    logic         ready_o;
    logic [2:0]   ctrl_i = '0;
    logic [W-1:0] data0_i = '0;
    logic [W-1:0] data1_i = '0;
    logic         valid_o;
    logic         ready_i = 1'b0;
    logic [W-1:0] result_o;
    logic [W-1:0] result_hi_o;
    logic         carry_o;
    logic         zero_o;
    logic         err_o;

    int n_checks = 0;
    int n_pass   = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .ctrl_i     (ctrl_i),
        .data0_i    (data0_i),
        .data1_i    (data1_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .result_o   (result_o),
        .result_hi_o(result_hi_o),
        .carry_o    (carry_o),
        .zero_o     (zero_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         c;
        logic         z;
        logic         e;
    } res_t;

    function automatic res_t ref_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        res_t r;
        longint unsigned ua, ub, full;
        ua = a;
        ub = b;
        r  = '0;
        case (op)
            3'd0: begin full = ua + ub; r.lo = W'(full); r.c = (full >> W) != 0; end
            3'd1: begin r.lo = W'(ua - ub); r.c = (ua < ub); end
            3'd2: begin full = ua * ub; r.lo = W'(full); r.hi = W'(full >> W); end
            3'd3: if (ub == 0) begin r.lo = '1; r.e = 1'b1; end else r.lo = W'(ua / ub);
            3'd4: if (ub == 0) begin r.lo = a;  r.e = 1'b1; end else r.lo = W'(ua % ub);
            3'd5: r.lo = a & b;
            3'd6: r.lo = a | b;
            default: r.lo = a ^ b;
        endcase
        r.z = (r.lo == '0);
        return r;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model: an accepted op yields its result after 1 cycle, or W+1
    // cycles for div/mod with a nonzero divisor; it is held until ready_i.
    logic m_live   = 1'b0;
    logic m_pend   = 1'b0;
    logic m_have   = 1'b0;
    logic m_zeroed = 1'b0;
    int   m_cnt    = 0;
    res_t m_exp    = '0;

    always @(posedge clk) begin
        if (rst_i) begin
            m_live   <= 1'b1;
            m_pend   <= 1'b0;
            m_have   <= 1'b0;
            m_zeroed <= 1'b1;
        end else if (m_live) begin
            if (m_have) begin
                if (ready_i) m_have <= 1'b0;
            end else if (m_pend) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_pend <= 1'b0;
                    m_have <= 1'b1;
                end
            end else if (valid_i) begin
                m_exp    <= ref_op(ctrl_i, data0_i, data1_i);
                m_zeroed <= 1'b0;
                if ((ctrl_i == 3'd3 || ctrl_i == 3'd4) && data1_i != '0) begin
                    m_pend <= 1'b1;
                    m_cnt  <= W;
                end else begin
                    m_have <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("mdl_ready", ready_o, !(m_pend || m_have));
            check("mdl_valid", valid_o, m_have);
            if (m_have) begin
                check("mdl_lo", result_o, m_exp.lo);
                check("mdl_hi", result_hi_o, m_exp.hi);
                check("mdl_carry", carry_o, m_exp.c);
                check("mdl_zero", zero_o, m_exp.z);
                check("mdl_err", err_o, m_exp.e);
            end else if (m_zeroed) begin
                check("mdl_rst_outs", {result_o, result_hi_o, carry_o, zero_o, err_o}, '0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic op_start(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        valid_i = 1'b1;
        ctrl_i  = op;
        data0_i = a;
        data1_i = b;
        tick();
        valid_i = 1'b0;
        ctrl_i  = 3'($urandom);
        data0_i = W'($urandom);
        data1_i = W'($urandom);
    endtask

    task automatic wait_result(output int lat);
        lat = 1;
        while (!valid_o && lat <= W + 4) begin
            check("busy_ready_low", ready_o, 1'b0);
            tick();
            lat++;
        end
        check("result_arrives", valid_o, 1'b1);
    endtask

    task automatic consume();
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        check("idle_ready", ready_o, 1'b1);
        check("idle_valid", valid_o, 1'b0);
    endtask

    task automatic run_op(input string nm, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] lo, input logic [W-1:0] hi,
                          input logic c, input logic e, input int lat_exp);
        int lat;
        op_start(op, a, b);
        wait_result(lat);
        check({nm, "_lat"}, lat, lat_exp);
        check({nm, "_lo"}, result_o, lo);
        check({nm, "_hi"}, result_hi_o, hi);
        check({nm, "_carry"}, carry_o, c);
        check({nm, "_zero"}, zero_o, (lo == '0));
        check({nm, "_err"}, err_o, e);
        consume();
    endtask

    initial begin
        tick();
        tick();
        rst_i = 1'b0;
        check("rst_ready", ready_o, 1'b1);
        check("rst_valid", valid_o, 1'b0);
        check("rst_outs", {result_o, result_hi_o, carry_o, zero_o, err_o}, '0);

        run_op("add1", 3'd0, 8'd200, 8'd23, 8'hDF, 8'h00, 1'b0, 1'b0, 1);
        run_op("add2", 3'd0, 8'd200, 8'd100, 8'h2C, 8'h00, 1'b1, 1'b0, 1);
        run_op("sub1", 3'd1, 8'd23, 8'd21, 8'h02, 8'h00, 1'b0, 1'b0, 1);
        run_op("sub2", 3'd1, 8'd21, 8'd23, 8'hFE, 8'h00, 1'b1, 1'b0, 1);
        run_op("mul1", 3'd2, 8'd10, 8'd12, 8'h78, 8'h00, 1'b0, 1'b0, 1);
        run_op("mul2", 3'd2, 8'd200, 8'd3, 8'h58, 8'h02, 1'b0, 1'b0, 1);
        run_op("div1", 3'd3, 8'd10, 8'd2, 8'h05, 8'h00, 1'b0, 1'b0, W + 1);
        run_op("mod1", 3'd4, 8'd9, 8'd3, 8'h00, 8'h00, 1'b0, 1'b0, W + 1);
        run_op("div0", 3'd3, 8'd37, 8'd0, 8'hFF, 8'h00, 1'b0, 1'b1, 1);
        run_op("mod0", 3'd4, 8'd37, 8'd0, 8'h25, 8'h00, 1'b0, 1'b1, 1);
        run_op("and1", 3'd5, 8'hF0, 8'h3C, 8'h30, 8'h00, 1'b0, 1'b0, 1);
        run_op("xor1", 3'd7, 8'hAA, 8'hAA, 8'h00, 8'h00, 1'b0, 1'b0, 1);

        // Backpressure: result held, new requests refused while not consumed.
        begin
            int lat;
            op_start(3'd2, 8'd200, 8'd3);
            wait_result(lat);
            for (int i = 0; i < 5; i++) begin
                valid_i = 1'b1;
                ctrl_i  = 3'd0;
                data0_i = W'($urandom);
                data1_i = W'($urandom);
                tick();
                check("bp_valid", valid_o, 1'b1);
                check("bp_ready", ready_o, 1'b0);
                check("bp_lo", result_o, 8'h58);
                check("bp_hi", result_hi_o, 8'h02);
            end
            valid_i = 1'b0;
            consume();
            run_op("bp_next", 3'd1, 8'd23, 8'd21, 8'h02, 8'h00, 1'b0, 1'b0, 1);
        end

        // Reset lands in the 4th BUSY cycle of 200/7.
        op_start(3'd3, 8'd200, 8'd7);
        tick();
        tick();
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("mid_rst_ready", ready_o, 1'b1);
        check("mid_rst_valid", valid_o, 1'b0);
        check("mid_rst_outs", {result_o, result_hi_o, carry_o, zero_o, err_o}, '0);
        for (int i = 0; i < W + 3; i++) begin
            tick();
            check("mid_rst_no_result", valid_o, 1'b0);
        end
        run_op("div7", 3'd3, 8'd200, 8'd7, 8'h1C, 8'h00, 1'b0, 1'b0, W + 1);
        run_op("mod7", 3'd4, 8'd200, 8'd7, 8'h04, 8'h00, 1'b0, 1'b0, W + 1);

        // Randomized traffic; the model process checks every cycle.
        for (int i = 0; i < 4000; i++) begin
            valid_i = ($urandom_range(0, 2) != 0);
            ctrl_i  = 3'($urandom);
            data0_i = W'($urandom);
            case ($urandom_range(0, 3))
                0:       data1_i = '0;
                1:       data1_i = W'($urandom_range(1, 9));
                default: data1_i = W'($urandom);
            endcase
            ready_i = ($urandom_range(0, 1) != 0);
            rst_i   = ($urandom_range(0, 299) == 0);
            tick();
        end
        valid_i = 1'b0;
        ready_i = 1'b0;
        rst_i   = 1'b0;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, handshaked successor to the combinational 8-bit ALU (alu_top). It accepts one operation at a time over a valid/ready input channel. Results return over a valid/ready output channel with status flags. Add/sub/mul/logic ops complete in 1 cycle; div/mod use an iterative restoring divider taking WIDTH cycles. It sits between the operand/control source (test driver or future datapath sequencer) and the result consumer.

Parameters:
WIDTH, 8, operand and result width in bits (>=2).

Ports:
clk_i  input  1  clock; all state updates on rising edge.
rst_i  input  1  reset; synchronous, active-high.
valid_i  input  1  operation request valid.
ready_o  output  1  block can accept a request.
ctrl_i  input  3  opcode: 000 add, 001 sub, 010 mul, 011 div, 100 mod, 101 and, 110 or, 111 xor.
data0_i  input  WIDTH  operand A (dividend, minuend).
data1_i  input  WIDTH  operand B (divisor, subtrahend).
valid_o  output  1  result valid.
ready_i  input  1  consumer accepts result.
result_o  output  WIDTH  result; low half of product for mul.
result_hi_o  output  WIDTH  high half of product for mul; 0 for all other ops.
carry_o  output  1  add carry-out / sub borrow; 0 otherwise.
zero_o  output  1  result_o == 0.
err_o  output  1  div/mod with data1_i == 0.

Behaviour:
- Reset is synchronous and active-high: state->IDLE, ready_o=1, valid_o=0, result_o=0, result_hi_o=0, carry_o=0, zero_o=0, err_o=0. Reset wins over every other event, including mid-division (the divider is abandoned and no result is produced).
- All arithmetic is unsigned. Operands and ctrl are captured on the accept edge; input changes after acceptance have no effect.
- FSM states IDLE, BUSY, DONE. ready_o = (state==IDLE). valid_o = (state==DONE).
- IDLE: valid_i && ready_o -> accept.
  - add/sub/mul/and/or/xor: compute and register outputs, go to DONE. valid_o is high the cycle after acceptance (latency 1).
  - div/mod with data1_i != 0: load divider, go to BUSY.
  - div/mod with data1_i == 0: go directly to DONE with err_o=1. div gives result_o = all ones; mod gives result_o = data0_i.
- BUSY: one quotient bit per cycle, MSB first, WIDTH cycles. On the last cycle, register quotient (div) or remainder (mod) into result_o and go to DONE. valid_o is high WIDTH+1 cycles after acceptance. valid_i is ignored while in BUSY.
- DONE: outputs held stable while ready_i=0. On ready_i=1, go to IDLE; valid_o drops next cycle. No new request is accepted in DONE, so back-to-back single-cycle throughput is 1 op per 2 cycles.
- add: {carry_o,result_o} = A+B (WIDTH+1 bits).
- sub: result_o = A-B mod 2^WIDTH; carry_o = (A<B).
- mul: {result_hi_o,result_o} = A*B (2*WIDTH bits), never truncated.
- zero_o depends on result_o only; err_o is 0 for non-division ops.

Decomposition:
- Package alu_pkg holds the opcode localparams (OP_ADD..OP_XOR), the FSM state encoding and the 3-bit ctrl width.
- Sub-module alu_divider (iterative restoring divider, WIDTH parameter). Ports: start, dividend, divisor, done, quotient, remainder. alu_seq handles divide-by-zero itself and never starts the divider with a zero divisor.

Test Plan:
- Add, WIDTH=8: 200+23 -> result_o=0xDF, carry_o=0, valid_o 1 cycle after accept. Then 200+100 -> result_o=0x2C, carry_o=1.
- Sub/mul: 23-21 -> 0x02, carry_o=0. 21-23 -> 0xFE, carry_o=1. 10*12 -> 0x78/hi 0x00. 200*3 -> result_o=0x58, result_hi_o=0x02.
- Div/mod latency: 10/2 -> result_o=0x05, valid_o exactly 9 cycles after accept, ready_o low throughout. 9%3 -> result_o=0x00, zero_o=1.
- Divide by zero: 37/0 -> result_o=0xFF, err_o=1, latency 1. 37%0 -> result_o=0x25, err_o=1.
- Backpressure: hold ready_i=0 for 5 cycles after a result. Outputs stay stable, ready_o=0, and a valid_i pulse is not accepted. Raise ready_i -> IDLE next cycle, then accept the next request.
- Reset mid-division: assert rst_i on the 4th BUSY cycle of 200/7 -> next cycle all outputs at reset values, ready_o=1, no valid_o. A fresh 200/7 then gives 0x1C; 200%7 gives 0x04.
